rtlola_offset_hold_window_monitor: RTL and testbench

Hardware runtime monitor for a fixed stream specification. It has one 64-bit signed input stream, one event-driven output and two periodic outputs. The periodic outputs use two sliding-window aggregates and an offset/hold recursion. The block has two parts. A high-level controller (HLC) timestamps events and pushes them into a FIFO. A low-level controller (LLC) pops events and evaluates the streams. Internal queue, slide and enable strobes are exported for debug and verification.

---
 rtl/rtlola_offset_hold_window_monitor.sv | 221 ++++++++++++++++++++++
 tb/tb_rtlola_offset_hold_window_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtlola_offset_hold_window_monitor.sv
// Runtime monitor: a 64-bit input stream, a running-sum output and two
// periodic outputs built from two sliding windows (sum and count).
// The HLC timestamps events into a small FIFO; the LLC pops and evaluates
// one event every two cycles (fetch, then evaluate).
module rtlola_offset_hold_window_monitor #(
  parameter int unsigned PERIOD_CYCLES  = 500,
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned WINDOW_BUCKETS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [63:0] input_0,
  input  logic               new_input_0,
  output logic signed [63:0] output_0,
  output logic signed [63:0] output_1,
  output logic signed [63:0] output_2,
  output logic               output_0_aktv,
  output logic               output_1_aktv,
  output logic               output_2_aktv,
  output logic               q_push,
  output logic               q_pop,
  output logic               q_push_valid,
  output logic               q_pop_valid,
  output logic               slide_0,
  output logic               slide_1,
  output logic               enable_in0,
  output logic               enable_out0,
  output logic               enable_out1,
  output logic               enable_out2
);

  localparam int unsigned CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned NW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(PERIOD_CYCLES - 1);

  typedef struct packed {
    logic [63:0] value;
    logic        has_in;
    logic        is_tick;
  } event_t;

  typedef enum logic {S_IDLE, S_EVAL} llc_state_t;

  logic [CW-1:0] r_cnt;
  logic          w_tick;
  event_t        r_fifo [QUEUE_DEPTH];
  event_t        w_push_ev;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [NW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  llc_state_t    r_state;
  llc_state_t    w_state_next;
  event_t        r_cur;
  logic          w_eval;

  logic [63:0] r_out0;
  logic [63:0] r_out1;
  logic [63:0] r_out2;
  logic        r_o0_def;
  logic        r_o2_def;
  logic        r_aktv_in;
  logic        r_aktv_tick;
  logic [63:0] r_w0 [WINDOW_BUCKETS];
  logic [63:0] r_w1 [WINDOW_BUCKETS];

  logic [63:0] w_add;
  logic [63:0] w_inc;
  logic [63:0] w_o0_next;
  logic [63:0] w_w0_cur;
  logic [63:0] w_w1_cur;
  logic [63:0] w_w0_sum;
  logic [63:0] w_w1_sum;
  logic [63:0] w_o2_base;
  logic [63:0] w_o2_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset is folded in so no push/pop is reported while the block is held.
  assign w_tick       = (r_cnt == LAST_TICK);
  assign w_full       = (r_count == NW'(QUEUE_DEPTH));
  assign w_empty      = (r_count == '0);
  assign q_push       = rst & en & (new_input_0 | w_tick);
  assign q_pop        = rst & en & (r_state == S_IDLE) & ~w_empty;
  assign q_pop_valid  = q_pop;
  assign q_push_valid = q_push & (~w_full | q_pop);
  assign w_push_ev    = '{value: input_0, has_in: new_input_0, is_tick: w_tick};
  assign w_eval       = en & (r_state == S_EVAL);

  assign output_0      = r_out0;
  assign output_1      = r_out1;
  assign output_2      = r_out2;
  assign output_0_aktv = r_aktv_in;
  assign enable_in0    = r_aktv_in;
  assign enable_out0   = r_aktv_in;
  assign output_1_aktv = r_aktv_tick;
  assign output_2_aktv = r_aktv_tick;
  assign enable_out1   = r_aktv_tick;
  assign enable_out2   = r_aktv_tick;
  assign slide_0       = r_aktv_tick;
  assign slide_1       = r_aktv_tick;

  // Period counter: counts enabled cycles, wraps on the tick cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_cnt <= '0;
    else if (en) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
  end

  // Event FIFO; a simultaneous pop makes room for the push on a full queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (q_push_valid) begin
        r_fifo[r_wr_ptr] <= w_push_ev;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (q_pop_valid) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({q_push_valid, q_pop_valid})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // LLC state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_state <= S_IDLE;
    else if (en) r_state <= w_state_next;
  end

  // LLC next state: fetch on a pop, evaluate on the following cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (q_pop_valid) w_state_next = S_EVAL;
      S_EVAL:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Fetch register holding the event under evaluation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_cur <= '0;
    else if (q_pop_valid) r_cur <= r_fifo[r_rd_ptr];
  end

  // Stream arithmetic: input first, then window aggregates and out2 recursion.
  always_comb begin
    w_add     = r_cur.has_in ? r_cur.value : '0;
    w_inc     = r_cur.has_in ? 64'd1 : '0;
    w_o0_next = r_out0 + w_add;
    w_w0_cur  = r_w0[0] + w_add;
    w_w1_cur  = r_w1[0] + w_inc;
    w_w0_sum  = w_w0_cur;
    w_w1_sum  = w_w1_cur;
    for (int unsigned i = 1; i < WINDOW_BUCKETS; i++) begin
      w_w0_sum = w_w0_sum + r_w0[i];
      w_w1_sum = w_w1_sum + r_w1[i];
    end
    w_o2_base = r_o2_def ? r_out2 : ((r_o0_def | r_cur.has_in) ? w_o0_next : '0);
    w_o2_next = w_o2_base + w_w1_sum;
  end

  // Window buckets: index 0 is current; a tick shifts toward older buckets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < WINDOW_BUCKETS; i++) begin
        r_w0[i] <= '0;
        r_w1[i] <= '0;
      end
    end else if (w_eval) begin
      if (r_cur.is_tick) begin
        r_w0[0] <= '0;
        r_w1[0] <= '0;
        for (int unsigned i = 1; i < WINDOW_BUCKETS; i++) begin
          r_w0[i] <= (i == 1) ? w_w0_cur : r_w0[i-1];
          r_w1[i] <= (i == 1) ? w_w1_cur : r_w1[i-1];
        end
      end else begin
        r_w0[0] <= w_w0_cur;
        r_w1[0] <= w_w1_cur;
      end
    end
  end

  // Output registers, defined flags and one-cycle evaluation strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out0      <= '0;
      r_out1      <= '0;
      r_out2      <= '0;
      r_o0_def    <= 1'b0;
      r_o2_def    <= 1'b0;
      r_aktv_in   <= 1'b0;
      r_aktv_tick <= 1'b0;
    end else if (en) begin
      r_aktv_in   <= w_eval & r_cur.has_in;
      r_aktv_tick <= w_eval & r_cur.is_tick;
      if (w_eval && r_cur.has_in) begin
        r_out0   <= w_o0_next;
        r_o0_def <= 1'b1;
      end
      if (w_eval && r_cur.is_tick) begin
        r_out1   <= w_w0_sum;
        r_out2   <= w_o2_next;
        r_o2_def <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtlola_offset_hold_window_monitor.sv
// Bench for rtlola_offset_hold_window_monitor: directed tables and
// sequences plus randomized traffic against an event-queue reference model.
module tb_rtlola_offset_hold_window_monitor;

  localparam int P  = 500;
  localparam int D  = 4;
  localparam int WB = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic signed [63:0] input_0;
  logic               new_input_0;
  logic signed [63:0] output_0, output_1, output_2;
  logic output_0_aktv, output_1_aktv, output_2_aktv;
  logic q_push, q_pop, q_push_valid, q_pop_valid;
  logic slide_0, slide_1, enable_in0, enable_out0, enable_out1, enable_out2;

  rtlola_offset_hold_window_monitor #(
    .PERIOD_CYCLES (P),
    .QUEUE_DEPTH   (D),
    .WINDOW_BUCKETS(WB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .input_0(input_0), .new_input_0(new_input_0),
    .output_0(output_0), .output_1(output_1), .output_2(output_2),
    .output_0_aktv(output_0_aktv), .output_1_aktv(output_1_aktv), .output_2_aktv(output_2_aktv),
    .q_push(q_push), .q_pop(q_pop), .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
    .slide_0(slide_0), .slide_1(slide_1), .enable_in0(enable_in0), .enable_out0(enable_out0),
    .enable_out1(enable_out1), .enable_out2(enable_out2)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending events, an evaluator slot and
  // windows kept as a ring of buckets.
  typedef struct {
    logic [63:0] value;
    bit          has_in;
    bit          is_tick;
  } ev_t;

  ev_t             m_q[$];
  ev_t             m_cur;
  bit              m_busy;
  longint unsigned m_en_cycles;
  logic [63:0]     e_o0, e_o1, e_o2;
  bit              e_o0_def, e_o2_def;
  bit              e_a_in, e_a_tick;
  logic [63:0]     m_sum [WB];
  logic [63:0]     m_cntb[WB];
  int              m_cur_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit last_qpv, last_qpop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_en_cycles = 0;
    e_o0 = '0; e_o1 = '0; e_o2 = '0;
    e_o0_def = 0; e_o2_def = 0; e_a_in = 0; e_a_tick = 0;
    m_cur_b = 0;
    for (int b = 0; b < WB; b++) begin m_sum[b] = '0; m_cntb[b] = '0; end
  endtask

  function automatic bit m_tick();
    return (m_en_cycles % P) == P - 1;
  endfunction

  task automatic model_eval(input ev_t ev);
    logic [63:0] w0, w1, base;
    if (ev.has_in) begin
      e_o0 = e_o0 + ev.value;
      e_o0_def = 1;
      m_sum[m_cur_b]  = m_sum[m_cur_b] + ev.value;
      m_cntb[m_cur_b] = m_cntb[m_cur_b] + 64'd1;
      e_a_in = 1;
    end
    if (ev.is_tick) begin
      w0 = '0; w1 = '0;
      for (int b = 0; b < WB; b++) begin w0 = w0 + m_sum[b]; w1 = w1 + m_cntb[b]; end
      e_o1 = w0;
      base = e_o2_def ? e_o2 : (e_o0_def ? e_o0 : 64'd0);
      e_o2 = base + w1;
      e_o2_def = 1;
      m_cur_b = (m_cur_b + 1) % WB;
      m_sum[m_cur_b]  = '0;
      m_cntb[m_cur_b] = '0;
      e_a_tick = 1;
    end
  endtask

  task automatic model_edge(input bit e, input bit nw, input logic [63:0] v);
    bit t, pop;
    ev_t ne;
    if (!e) return;
    t = m_tick();
    pop = !m_busy && m_q.size() > 0;
    e_a_in = 0; e_a_tick = 0;
    if (m_busy) begin model_eval(m_cur); m_busy = 0; end
    if (pop) begin m_cur = m_q.pop_front(); m_busy = 1; end
    if ((nw || t) && m_q.size() < D) begin
      ne.value = v; ne.has_in = nw; ne.is_tick = t;
      m_q.push_back(ne);
    end
    m_en_cycles++;
  endtask

  task automatic check_regs();
    chk("output_0", output_0, e_o0);
    chk("output_1", output_1, e_o1);
    chk("output_2", output_2, e_o2);
    chk("output_0_aktv", output_0_aktv, e_a_in);
    chk("output_1_aktv", output_1_aktv, e_a_tick);
    chk("output_2_aktv", output_2_aktv, e_a_tick);
    chk("enable_in0", enable_in0, e_a_in);
    chk("enable_out0", enable_out0, e_a_in);
    chk("enable_out1", enable_out1, e_a_tick);
    chk("enable_out2", enable_out2, e_a_tick);
    chk("slide_0", slide_0, e_a_tick);
    chk("slide_1", slide_1, e_a_tick);
  endtask

  task automatic step(input bit e, input bit nw, input logic [63:0] v);
    bit t, xpush, xpop, xpv;
    en = e; new_input_0 = nw; input_0 = v;
    #1;
    t     = m_tick();
    xpush = e && (nw || t);
    xpop  = e && !m_busy && m_q.size() > 0;
    xpv   = xpush && (m_q.size() < D || xpop);
    chk("q_push", q_push, xpush);
    chk("q_push_valid", q_push_valid, xpv);
    chk("q_pop", q_pop, xpop);
    chk("q_pop_valid", q_pop_valid, xpop);
    last_qpv  = q_push_valid;
    last_qpop = q_pop;
    @(posedge clk);
    model_edge(e, nw, v);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b1; new_input_0 = 1'b1; input_0 = 64'sd5;
    model_reset();
    #1;
    chk("rst_q_push", q_push, 0);
    chk("rst_q_push_valid", q_push_valid, 0);
    chk("rst_q_pop", q_pop, 0);
    check_regs();
    @(posedge clk); #1;
    chk("rst_q_push_edge", q_push, 0);
    check_regs();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [63:0] val;
    logic [63:0] exp_o0;
  } vec_t;

  initial begin
    vec_t        tbl[5];
    logic [63:0] t_o1[3];
    logic [63:0] t_o2[3];
    bit          ovf_pv[12];
    int          first, n_push, n_ak;
    bit          found;

    tbl[0] = '{64'd1, 64'd1};  tbl[1] = '{64'd2, 64'd3};  tbl[2] = '{64'd3, 64'd6};
    tbl[3] = '{64'd4, 64'd10}; tbl[4] = '{64'd5, 64'd15};
    t_o1[0] = 64'd3; t_o1[1] = 64'd3; t_o1[2] = 64'd0;
    t_o2[0] = 64'd5; t_o2[1] = 64'd7; t_o2[2] = 64'd7;
    for (int i = 0; i < 12; i++) ovf_pv[i] = (i < 8) || (i % 2 == 1);

    // Reset state, then first tick timing with no input.
    do_reset();
    first = -1;
    for (int s = 1; s <= 510; s++) begin
      step(1, 0, '0);
      if (output_1_aktv && first < 0) first = s;
    end
    chk("first_tick_step", 64'(first), 64'd502);
    chk("first_tick_o2", output_2, 64'd0);

    // Running sum, no ticks.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, tbl[i].val);
      step(1, 0, '0);
      step(1, 0, '0);
      chk("sum_aktv0", output_0_aktv, 1);
      chk("sum_o0", output_0, tbl[i].exp_o0);
      chk("sum_aktv1", output_1_aktv, 0);
      repeat (7) step(1, 0, '0);
    end

    // Two inputs then three ticks: windows age out.
    do_reset();
    step(1, 1, 64'd1);
    repeat (9) step(1, 0, '0);
    step(1, 1, 64'd2);
    repeat (9) step(1, 0, '0);
    for (int k = 0; k < 3; k++) begin
      found = 0;
      for (int s = 0; s < 600 && !found; s++) begin
        step(1, 0, '0);
        if (output_1_aktv) found = 1;
      end
      chk("tick_seen", found, 1);
      chk("tick_o1", output_1, t_o1[k]);
      chk("tick_o2", output_2, t_o2[k]);
      chk("tick_slide0", slide_0, 1);
      chk("tick_slide1", slide_1, 1);
    end

    // Input in the exact tick cycle.
    do_reset();
    repeat (499) step(1, 0, '0);
    step(1, 1, 64'd4);
    step(1, 0, '0);
    step(1, 0, '0);
    chk("same_aktv0", output_0_aktv, 1);
    chk("same_aktv1", output_1_aktv, 1);
    chk("same_aktv2", output_2_aktv, 1);
    chk("same_o0", output_0, 64'd4);
    chk("same_o1", output_1, 64'd4);
    chk("same_o2", output_2, 64'd5);

    // FIFO overflow: 12 back-to-back inputs, values 9 and 11 are lost.
    do_reset();
    repeat (5) step(1, 0, '0);
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 64'(i + 1));
      chk("ovf_push_valid", last_qpv, ovf_pv[i]);
      chk("ovf_pop", last_qpop, 64'(i % 2));
    end
    repeat (30) step(1, 0, '0);
    chk("ovf_sum", output_0, 64'd58);

    // Freeze: 1000 disabled cycles, then counting resumes.
    repeat (5) step(1, 0, '0);
    n_push = 0; n_ak = 0;
    for (int i = 0; i < 1000; i++) begin
      step(0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
      if (q_push) n_push++;
      if (output_0_aktv || output_1_aktv) n_ak++;
    end
    chk("freeze_push", 64'(n_push), 0);
    chk("freeze_aktv", 64'(n_ak), 0);
    first = -1;
    for (int s = 1; s <= 460; s++) begin
      step(1, 0, '0);
      if (output_1_aktv && first < 0) first = s;
    end
    chk("resume_tick_step", 64'(first), 64'd450);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0,
           ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($signed($urandom_range(0, 200)) - 100));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
